// File: rtl/shift_add_multiplier.sv
// Multi-cycle unsigned shift-and-add multiplier.
// A single adder is reused over WIDTH cycles; issue is start/busy, completion is done/ack.
module shift_add_multiplier #(
    parameter int WIDTH = 64,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    input  logic                 ack,
    output logic [2*WIDTH-1:0]   product
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [WIDTH:0]   addend;
    logic [WIDTH:0]   sum;
    logic             accept;

    always_comb begin
        addend   = acc_lo_q[0] ? {1'b0, m_q} : '0;
        sum      = {1'b0, acc_hi_q} + addend;
        accept   = start && ((state_q == IDLE) ||
                             (state_q == DONE && ack));

        state_d  = state_q;
        m_d      = m_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        cnt_d    = cnt_q;

        if (accept) begin
            state_d  = RUN;
            m_d      = a;
            acc_hi_d = '0;
            acc_lo_d = b;
            cnt_d    = '0;
        end else begin
            unique case (state_q)
                IDLE: ;
                RUN: begin
                    // Carry-out lands in the MSB of the high half.
                    acc_hi_d = sum[WIDTH:1];
                    acc_lo_d = {sum[0], acc_lo_q[WIDTH-1:1]};
                    cnt_d    = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST) state_d = DONE;
                end
                DONE: if (ack) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end

        busy_d = (state_d == RUN) || (state_d == DONE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            m_q      <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            m_q      <= m_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = {acc_hi_q, acc_lo_q};

endmodule

// File: doc/shift_add_multiplier.md
Name: shift_add_multiplier

Overview:
- Multi-cycle unsigned multiplier for the ALU, built as a controller that sequences one WIDTH-bit ripple adder over WIDTH iterations.
- The algorithm is shift-and-add.
- Issue is through a start/busy handshake and completion through a done/ack handshake.
- It sits beside the single-cycle ALU and serves MUL-class instructions, which stall the pipeline on busy.

Parameters:
WIDTH, 64, operand width in bits; product is 2*WIDTH bits; legal range 2..64.
CNT_W, $clog2(WIDTH+1), iteration counter width (derived; do not override).

Ports:
clk  input  1  single clock, all state updates on rising edge.
reset  input  1  synchronous, active-high; clears all state at the next rising edge.
start  input  1  request to begin; sampled only when idle (state IDLE or DONE-with-ack).
a  input  WIDTH  multiplicand, captured on accepted start.
b  input  WIDTH  multiplier, captured on accepted start.
busy  output  1  high in RUN and DONE; start is not accepted while busy, except DONE with ack.
done  output  1  high in DONE; product is valid.
ack  input  1  consumer has taken product; meaningful only while done.
product  output  2*WIDTH  a*b, unsigned, exact (no overflow possible).

Behaviour:
- Reset: state=IDLE, busy=0, done=0, product=0, counter=0, and the internal multiplicand, accumulator and carry are all 0.
- Reset has priority over every other input, including mid-RUN and DONE. The operation in flight is discarded with no partial result visible.
- States and transitions:
  - IDLE: start=1 captures a into the multiplicand register M. It loads the accumulator {ACC_HI, ACC_LO} = {0, b}, sets counter=0 and goes to RUN. With start=0 the block stays in IDLE.
  - RUN: one iteration per cycle. If ACC_LO[0]=1, {c, sum} = ACC_HI + M; otherwise {c, sum} = {0, ACC_HI}. Then {ACC_HI, ACC_LO} <= {c, sum, ACC_LO} >> 1, a (2*WIDTH+1)-bit shift whose LSB is dropped. counter increments.
  - RUN exit: after the WIDTH-th iteration (counter == WIDTH-1 at the edge), the state goes to DONE. start is ignored in RUN.
  - DONE: done=1 and product = {ACC_HI, ACC_LO}, held stable until ack=1.
  - DONE with ack=1 and start=0: go to IDLE, done=0. product keeps its value until the next start is accepted.
  - DONE with ack=1 and start=1: back-to-back. The block captures the new a/b and goes directly to RUN with no idle bubble.
  - DONE with ack=0: start is ignored.
- Latency: start sampled high in cycle N (from IDLE) puts the block in RUN for cycles N+1..N+WIDTH. done=1 from cycle N+WIDTH+1. Throughput is one product per WIDTH+1 cycles when back-to-back.
- Operand capture: a and b may change freely after the accepting edge; the result depends only on the captured values.
- Carry: the adder carry-out is the (2*WIDTH+1)th bit. It is shifted into ACC_HI MSB in the same cycle and never lost. Example: M=all-ones with every multiplier bit 1 must produce (2^WIDTH-1)^2.
- No early termination: b=0 and b=1 still take WIDTH iterations.
- busy=1 exactly when state is RUN or DONE. done=1 exactly when state is DONE.
- product during RUN is don't-care to consumers but must not be X after reset.

Test Plan:
- WIDTH=8, reset then start with a=13, b=11 -> busy=1 next cycle; done=1 exactly 9 cycles after the start cycle; product=143 (0x008F). ack returns the block to IDLE with busy=0.
- WIDTH=8, a=0xFF, b=0xFF -> product=0xFE01. Checks carry-out retention.
- WIDTH=8, a=0x00, b=0xA5 and a=0x5A, b=0x00 -> product=0 after the full 8 RUN cycles each; no early done.
- WIDTH=8, start pulses in RUN and in DONE with ack=0 -> ignored. Operands change after acceptance -> no effect; result stays that of the first operands.
- WIDTH=8, done with ack=1 and start=1 (a=3, b=7) in the same cycle -> RUN next cycle; second done 9 cycles later with product=21; first product held until that ack.
- WIDTH=8, reset asserted at RUN cycle 4 -> next cycle state IDLE, busy=0, done=0, product=0. A fresh start (a=2, b=2) then yields product=4.
- WIDTH=64, exhaustive corner set (0, 1, 2^64-1, 2^63) x same set plus 1000 random pairs -> product equals the 128-bit reference a*b.
